// File: rtl/my_bitwise_pipe_if.sv
// rtl/my_bitwise_pipe_if.sv - operation/result handshake bundle for my_bitwise_pipe
interface my_bitwise_pipe_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, out_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, out_count
  );
endinterface

// File: rtl/my_bitwise_pipe.sv
// rtl/my_bitwise_pipe.sv - bitwise ALU feeding an elastic valid/ready register pipeline
module my_bitwise_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  my_bitwise_pipe_if.slave bus
);
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  op_result;
  logic              in_xfer;
  logic              out_xfer;

  always_comb begin
    op_result = bus.a;
    case (bus.op)
      3'b000:  op_result = ~bus.a;
      3'b001:  op_result = bus.a & bus.b;
      3'b010:  op_result = bus.a | bus.b;
      3'b011:  op_result = bus.a ^ bus.b;
      3'b100:  op_result = ~(bus.a & bus.b);
      3'b101:  op_result = ~(bus.a | bus.b);
      3'b110:  op_result = ~(bus.a ^ bus.b);
      default: op_result = bus.a;
    endcase
  end

  // Ready ripples back from the output; an accumulator keeps the chain free of self-feedback.
  always_comb begin : ready_chain
    logic acc;
    acc   = bus.out_ready;
    ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc      = !valid_q[i] || acc;
      ready[i] = acc;
    end
  end

  assign in_xfer  = bus.in_valid && ready[0];
  assign out_xfer = valid_q[STAGES-1] && bus.out_ready;

  // Data only moves alongside a valid bit, so the last stage stays 0 until a real result lands.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (ready[0]) valid_d[0] = bus.in_valid;
    if (in_xfer) data_d[0] = op_result;
    for (int i = 1; i < STAGES; i++) begin
      if (ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
    if (out_xfer) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out       = data_q[STAGES-1];
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_my_bitwise_pipe.sv
// tb/tb_my_bitwise_pipe.sv - directed self-checking bench for my_bitwise_pipe
module tb_my_bitwise_pipe;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  my_bitwise_pipe_if #(.WIDTH(16), .CNT_W(8)) if_a ();
  my_bitwise_pipe_if #(.WIDTH(16), .CNT_W(2)) if_w ();
  my_bitwise_pipe_if #(.WIDTH(16), .CNT_W(8)) if_s ();

  my_bitwise_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(8)) dut_a (.clk(clk), .reset(rst), .bus(if_a));
  my_bitwise_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(2)) dut_w (.clk(clk), .reset(rst), .bus(if_w));
  my_bitwise_pipe #(.WIDTH(16), .STAGES(3), .CNT_W(8)) dut_s (.clk(clk), .reset(rst), .bus(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.in_valid  = 1'b1;
    if_a.out_ready = 1'b1;
    if_a.op        = 3'b111;
    if_a.a         = 16'hBEEF;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", if_a.out); end
    checks++; if (if_a.out_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", if_a.out_count); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if_a.in_ready); end
    if_a.in_valid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (if_a.out_valid !== 1'b0 || if_a.out !== 16'h0000) begin
        errors++; $display("FAIL post_reset_idle: got valid=%b out=%h expected valid=0 out=0000", if_a.out_valid, if_a.out);
      end
    end
    checks++; if (if_a.out_count !== 8'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", if_a.out_count); end
  endtask

  task automatic test_not();
    logic [15:0] av [3];
    logic [15:0] ev [3];
    av = '{16'h0000, 16'hFFFF, 16'hF8FC};
    ev = '{16'hFFFF, 16'h0000, 16'h0703};
    if_a.out_ready = 1'b1;
    if_a.op        = 3'b000;
    if_a.b         = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        if_a.in_valid = 1'b1;
        if_a.a        = av[c];
      end else begin
        if_a.in_valid = 1'b0;
      end
      checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL not_in_ready c%0d: got %b expected 1", c, if_a.in_ready); end
      step();
      if (c >= 1) begin
        checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== ev[c-1]) begin
          errors++; $display("FAIL not_out cycle%0d: got valid=%b out=%h expected valid=1 out=%h", c + 1, if_a.out_valid, if_a.out, ev[c-1]);
        end
      end
    end
    step();
    checks++; if (if_a.out_count !== 8'd3) begin errors++; $display("FAIL not_count: got %0d expected 3", if_a.out_count); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL not_drained: got %b expected 0", if_a.out_valid); end
  endtask

  task automatic test_binary_ops();
    logic [15:0] ev [7];
    ev = '{16'h0F00, 16'hFF0F, 16'hF00F, 16'hF0FF, 16'h00F0, 16'h0FF0, 16'hFF00};
    if_a.out_ready = 1'b1;
    if_a.a         = 16'hFF00;
    if_a.b         = 16'h0F0F;
    for (int c = 0; c < 8; c++) begin
      if (c < 7) begin
        if_a.in_valid = 1'b1;
        if_a.op       = 3'(c + 1);
      end else begin
        if_a.in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== ev[c-1]) begin
          errors++; $display("FAIL binop op%0d: got valid=%b out=%h expected valid=1 out=%h", c, if_a.out_valid, if_a.out, ev[c-1]);
        end
      end
    end
    step();
    checks++; if (if_a.out_count !== 8'd10) begin errors++; $display("FAIL binop_count: got %0d expected 10", if_a.out_count); end
  endtask

  task automatic test_backpressure();
    if_a.out_ready = 1'b0;
    if_a.op        = 3'b111;
    if_a.in_valid  = 1'b1;
    if_a.a         = 16'h1111;
    step();
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one_held: got %b expected 1", if_a.in_ready); end
    if_a.a = 16'h2222;
    step();
    if_a.a = 16'h3333;
    for (int c = 0; c < 3; c++) begin
      checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready c%0d: got %b expected 0", c, if_a.in_ready); end
      checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== 16'h1111) begin
        errors++; $display("FAIL bp_hold c%0d: got valid=%b out=%h expected valid=1 out=1111", c, if_a.out_valid, if_a.out);
      end
      if (c < 2) step();
    end
    if_a.out_ready = 1'b1;
    #1;
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", if_a.in_ready); end
    step();
    if_a.in_valid = 1'b0;
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== 16'h2222) begin errors++; $display("FAIL bp_second: got valid=%b out=%h expected 2222", if_a.out_valid, if_a.out); end
    step();
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== 16'h3333) begin errors++; $display("FAIL bp_third: got valid=%b out=%h expected 3333", if_a.out_valid, if_a.out); end
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.out_count !== 8'd13) begin errors++; $display("FAIL bp_count: got %0d expected 13", if_a.out_count); end
  endtask

  task automatic test_reset_mid();
    if_a.out_ready = 1'b0;
    if_a.op        = 3'b111;
    if_a.in_valid  = 1'b1;
    if_a.a         = 16'hAAAA;
    step();
    if_a.a = 16'h5555;
    step();
    if_a.in_valid = 1'b0;
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out !== 16'hAAAA) begin errors++; $display("FAIL rm_filled: got valid=%b out=%h expected AAAA", if_a.out_valid, if_a.out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.out !== 16'h0000) begin errors++; $display("FAIL rm_out: got %h expected 0000", if_a.out); end
    checks++; if (if_a.out_count !== 8'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", if_a.out_count); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b expected 1", if_a.in_ready); end
    step();
    rst = 1'b0;
    if_a.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (if_a.out_valid !== 1'b0 || if_a.out !== 16'h0000) begin
        errors++; $display("FAIL rm_ghost c%0d: got valid=%b out=%h expected valid=0 out=0000", c, if_a.out_valid, if_a.out);
      end
    end
    checks++; if (if_a.out_count !== 8'd0) begin errors++; $display("FAIL rm_count_after: got %0d expected 0", if_a.out_count); end
  endtask

  task automatic test_counter_wrap();
    if_w.out_ready = 1'b1;
    if_w.op        = 3'b000;
    if_w.a         = 16'h00FF;
    for (int c = 0; c < 5; c++) begin
      if_w.in_valid = 1'b1;
      step();
    end
    if_w.in_valid = 1'b0;
    step();
    checks++; if (if_w.out_count !== 2'd0) begin errors++; $display("FAIL wrap_at_4: got %0d expected 0", if_w.out_count); end
    step();
    checks++; if (if_w.out_count !== 2'd1) begin errors++; $display("FAIL wrap_at_5: got %0d expected 1", if_w.out_count); end
    checks++; if (if_w.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %b expected 0", if_w.out_valid); end
  endtask

  task automatic test_back_to_back();
    int seen;
    int first_cyc;
    seen      = 0;
    first_cyc = -1;
    if_s.out_ready = 1'b1;
    if_s.op        = 3'b111;
    for (int c = 0; c < 10; c++) begin
      if_s.in_valid = 1'b1;
      if_s.a        = 16'(16'h0100 + c);
      #1;
      checks++; if (if_s.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %b expected 1", c, if_s.in_ready); end
      step();
      if (if_s.out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c + 1;
        checks++; if (if_s.out !== 16'(16'h0100 + seen)) begin
          errors++; $display("FAIL stream_order #%0d: got %h expected %h", seen, if_s.out, 16'(16'h0100 + seen));
        end
        seen++;
      end
    end
    checks++; if (seen != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", seen); end
    checks++; if (first_cyc != 3) begin errors++; $display("FAIL stream_latency: got %0d expected 3", first_cyc); end
    if_s.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (if_s.out_valid === 1'b1) begin
        checks++; if (if_s.out !== 16'(16'h0100 + seen)) begin
          errors++; $display("FAIL stream_tail #%0d: got %h expected %h", seen, if_s.out, 16'(16'h0100 + seen));
        end
        seen++;
      end
    end
    checks++; if (seen != 10) begin errors++; $display("FAIL stream_total: got %0d expected 10", seen); end
    checks++; if (if_s.out_count !== 8'd10) begin errors++; $display("FAIL stream_out_count: got %0d expected 10", if_s.out_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    if_a.in_valid = 1'b0; if_a.out_ready = 1'b0; if_a.op = 3'b000; if_a.a = '0; if_a.b = '0;
    if_w.in_valid = 1'b0; if_w.out_ready = 1'b0; if_w.op = 3'b000; if_w.a = '0; if_w.b = '0;
    if_s.in_valid = 1'b0; if_s.out_ready = 1'b0; if_s.op = 3'b000; if_s.a = '0; if_s.b = '0;
    step();
    test_reset();
    test_not();
    test_binary_ops();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/my_bitwise_pipe.md
MY_BITWISE_PIPE -- requirements
Module: my_bitwise_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; SHALL be supported for any value >= 1.
REQ-002 Parameter STAGES, default 2, number of register stages (the latency); SHALL be supported for any value >= 1.
REQ-003 Parameter CNT_W, default 8, width of the completed-transfer counter.
REQ-004 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port in_valid, input, 1, upstream offers an operation this cycle.
REQ-007 Port in_ready, output, 1, block accepts the offered operation this cycle.
REQ-008 Port op, input, 3, operation select, sampled with the input data.
REQ-009 Port a, input, WIDTH, first operand.
REQ-010 Port b, input, WIDTH, second operand; ignored for unary ops.
REQ-011 Port out_valid, output, 1, result available at out.
REQ-012 Port out_ready, input, 1, downstream accepts the result.
REQ-013 Port out, output, WIDTH, result data.
REQ-014 Port out_count, output, CNT_W, number of results transferred out, modulo 2^CNT_W.

Function
REQ-015 Op encoding SHALL be: 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b, 100 NAND, 101 NOR, 110 XNOR, 111 PASS a; all ops bitwise across WIDTH bits.
REQ-016 The result SHALL be computed combinationally from a, b and op at input acceptance and captured into stage 0; later stages carry data and a valid bit only.
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-018 Stage i SHALL be able to load when it is empty or stage i+1 loads/drains this cycle (ready[i] = !valid[i] || ready[i+1], with ready[STAGES] = out_ready); in_ready = ready[0].
REQ-019 in_ready SHALL depend on out_ready and stage valids only, never on in_valid.
REQ-020 With no backpressure, a result SHALL appear at out exactly STAGES cycles after its input transfer, and throughput SHALL be one result per cycle.
REQ-021 While out_valid=1 and out_ready=0, out SHALL hold stable and no held result SHALL be overwritten or dropped.
REQ-022 A full pipeline with out_ready=1 and in_valid=1 in the same cycle SHALL drain one result and accept one input, keeping in_ready=1.
REQ-023 Capacity SHALL be exactly STAGES results; results SHALL leave in acceptance order with no duplication or loss.
REQ-024 out_valid SHALL equal the valid bit of the last stage; out SHALL equal that stage's data.
REQ-025 out_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-026 An empty stage's data contents are don't-care, but out SHALL be 0 whenever no result has yet reached the last stage since reset.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, clear all valid bits, set out_valid=0, out=0 and out_count=0.
REQ-028 Any operations in flight when reset asserts SHALL be discarded and SHALL never appear at out.
REQ-029 While reset is high, in_ready SHALL be 1 (all stages empty) but no input transfer SHALL be recorded.
REQ-030 The first rising edge with reset low SHALL behave as from an empty pipeline.

Verification (WIDTH=16, STAGES=2, CNT_W=8 unless stated)
REQ-031 NOT: op=000, a=0x0000, then 0xFFFF, then 0xF8FC on consecutive cycles with out_ready=1 -> out reads 0xFFFF, 0x0000, 0x0703 on cycles 2, 3, 4 after the first accept, and out_count=3.
REQ-032 Binary ops: a=0xFF00, b=0x0F0F -> AND 0x0F00, OR 0xFF0F, XOR 0xF00F, NAND 0xF0FF, NOR 0x00F0, XNOR 0x0FF0, PASS 0xFF00.
REQ-033 Backpressure: hold out_ready=0 and offer 3 items -> 2 accepted, then in_ready=0 and out stays stable; raise out_ready -> items emerge in order, the third is accepted, and no item is lost or duplicated.
REQ-034 Reset mid-operation: fill 2 items, assert reset between clock edges -> out_valid=0, out=0, out_count=0 at once; after release, the old items never appear.
REQ-035 Counter wrap: with CNT_W=2, perform 5 output transfers -> out_count=1.
REQ-036 Streaming full pipeline: with STAGES=3, drive in_valid=1 and out_ready=1 for 10 cycles -> in_ready stays 1 throughout and 8 results appear in order, the first 3 cycles after the first accept.
